// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear FSM with lap history for the stopwatch display chain.
// Raw board inputs are synchronized and debounced before they reach the FSM.

module stopwatch_ctrl_db #(
    parameter int p_db_cycles  = 1_000_000,
    parameter bit p_both_edges = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_evt
);
    localparam int CW = (p_db_cycles > 2) ? $clog2(p_db_cycles) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(p_db_cycles - 1);

    logic [1:0]    sync_q;
    logic          lvl_q, lvl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          evt_q, evt_d;

    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        evt_d = 1'b0;
        if (sync_q[1] == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Level accepted: the event fires on the same edge as the update.
            lvl_d = sync_q[1];
            cnt_d = '0;
            evt_d = sync_q[1] | p_both_edges;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync_q <= '0;
            lvl_q  <= 1'b0;
            cnt_q  <= '0;
            evt_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], i_raw};
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
            evt_q  <= evt_d;
        end
    end

    assign o_evt = evt_q;
endmodule

module stopwatch_ctrl #(
    parameter int p_width     = 6,
    parameter int p_depth     = 3,
    parameter int p_db_cycles = 1_000_000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start_stop,
    input  logic                       i_lap,
    input  logic                       i_clear,
    input  logic [p_width-1:0]         i_val,
    output logic                       o_tick_stop,
    output logic                       o_cnt_rst,
    output logic [p_depth*p_width-1:0] o_hist,
    output logic [p_depth-1:0]         o_valid,
    output logic [1:0]                 o_state,
    output logic                       o_lap
);
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;

    // Input order: 0 start/stop, 1 lap, 2 clear. Only the lap switch reacts to both edges.
    localparam int               NUM_IN     = 3;
    localparam logic [NUM_IN-1:0] BOTH_EDGES = 3'b010;

    logic [NUM_IN-1:0] raw, evt;
    assign raw = {i_clear, i_lap, i_start_stop};

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_db
            stopwatch_ctrl_db #(
                .p_db_cycles (p_db_cycles),
                .p_both_edges(BOTH_EDGES[g])
            ) u_db (
                .i_clk(i_clk),
                .i_rst(i_rst),
                .i_raw(raw[g]),
                .o_evt(evt[g])
            );
        end
    endgenerate

    logic                       ev_start, ev_lap, ev_clear;
    logic [1:0]                 state_q, state_d;
    logic [p_depth*p_width-1:0] hist_q, hist_d;
    logic [p_depth-1:0]         valid_q, valid_d;
    logic                       tick_stop_q, tick_stop_d;
    logic                       cnt_rst_q, cnt_rst_d;
    logic                       lap_q, lap_d;
    logic                       capture;

    assign ev_start = evt[0];
    assign ev_lap   = evt[1];
    assign ev_clear = evt[2];

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        valid_d   = valid_q;
        cnt_rst_d = 1'b0;
        lap_d     = 1'b0;
        capture   = 1'b0;
        if (ev_clear) begin
            // Clear swallows any start or lap decoded on the same cycle.
            state_d   = S_IDLE;
            hist_d    = '0;
            valid_d   = '0;
            cnt_rst_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ev_start) state_d = S_RUN;
                end
                S_RUN: begin
                    if (ev_start) state_d = S_PAUSE;
                    capture = ev_lap;
                end
                S_PAUSE: begin
                    if (ev_start) state_d = S_RUN;
                    capture = ev_lap;
                end
                default: state_d = S_IDLE;
            endcase
            if (capture) begin
                hist_d  = {hist_q[(p_depth-1)*p_width-1:0], i_val};
                valid_d = {valid_q[p_depth-2:0], 1'b1};
                lap_d   = 1'b1;
            end
        end
        tick_stop_d = (state_d != S_RUN);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            hist_q      <= '0;
            valid_q     <= '0;
            tick_stop_q <= 1'b1;
            cnt_rst_q   <= 1'b0;
            lap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            valid_q     <= valid_d;
            tick_stop_q <= tick_stop_d;
            cnt_rst_q   <= cnt_rst_d;
            lap_q       <= lap_d;
        end
    end

    assign o_state     = state_q;
    assign o_hist      = hist_q;
    assign o_valid     = valid_q;
    assign o_tick_stop = tick_stop_q;
    assign o_cnt_rst   = cnt_rst_q;
    assign o_lap       = lap_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: scoreboard of expected history snapshots, one
// entry queued per lap toggle that should capture, popped on each o_lap pulse.

module tb_stopwatch_ctrl;
    localparam int W  = 6;
    localparam int D  = 3;
    localparam int DB = 4;
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_raw = 1'b0, lap_raw = 1'b0, clear_raw = 1'b0;
    logic [W-1:0]   val = '0;
    logic           tick_stop, cnt_rst, lap_pulse;
    logic [D*W-1:0] hist;
    logic [D-1:0]   valid;
    logic [1:0]     state;

    stopwatch_ctrl #(.p_width(W), .p_depth(D), .p_db_cycles(DB)) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_start_stop(start_raw),
        .i_lap       (lap_raw),
        .i_clear     (clear_raw),
        .i_val       (val),
        .o_tick_stop (tick_stop),
        .o_cnt_rst   (cnt_rst),
        .o_hist      (hist),
        .o_valid     (valid),
        .o_state     (state),
        .o_lap       (lap_pulse)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, n_lap = 0, n_cnt_rst = 0;
    logic [D*W+D-1:0] exp_q[$];
    logic [D*W+D-1:0] exp_v;
    logic [W-1:0]     m_hist[D];
    logic [D-1:0]     m_valid;
    logic [1:0]       m_state;

    function automatic logic [D*W-1:0] pack_hist();
        logic [D*W-1:0] p;
        for (int i = 0; i < D; i++) p[i*W +: W] = m_hist[i];
        return p;
    endfunction

    task automatic model_wipe();
        for (int i = 0; i < D; i++) m_hist[i] = '0;
        m_valid = '0;
    endtask

    task automatic model_capture(input logic [W-1:0] v);
        for (int i = D-1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = v;
        m_valid = {m_valid[D-2:0], 1'b1};
        exp_q.push_back({pack_hist(), m_valid});
    endtask

    // Pulse monitor: samples away from the clock edge.
    always @(posedge clk) begin
        #2;
        if (cnt_rst === 1'b1) n_cnt_rst++;
        if (lap_pulse === 1'b1) begin
            n_lap++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL lap_unexpected: o_lap with hist=%h valid=%b, no capture expected", hist, valid);
            end else begin
                exp_v = exp_q.pop_front();
                if ({hist, valid} !== exp_v) begin
                    errors++;
                    $display("FAIL lap_capture: got hist/valid %h, expected %h", {hist, valid}, exp_v);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name);
        logic [D*W+D+2:0] exp_o;
        exp_o = {m_state, m_state != S_RUN, pack_hist(), m_valid};
        checks++;
        if ({state, tick_stop, hist, valid} !== exp_o) begin
            errors++;
            $display("FAIL %s: got state/tick_stop/hist/valid %h, expected %h", name,
                     {state, tick_stop, hist, valid}, exp_o);
        end
    endtask

    // Start held for 10 cycles; state must flip exactly after edge k+6.
    task automatic press_start();
        logic [1:0] nxt;
        nxt = (m_state == S_RUN) ? S_PAUSE : S_RUN;
        start_raw = 1'b1;
        tick(6);
        checks++;
        if (state !== m_state) begin
            errors++;
            $display("FAIL start_early: state %b, expected %b", state, m_state);
        end
        tick(1);
        m_state = nxt;
        check_outputs("start_toggle");
        tick(3);
        start_raw = 1'b0;
        tick(8);
    endtask

    task automatic toggle_lap(input logic [W-1:0] v, input bit capt);
        val = v;
        lap_raw = ~lap_raw;
        if (capt) model_capture(v);
        tick(10);
    endtask

    task automatic test_reset();
        logic [D*W+D+3:0] exp_rst;
        exp_rst = {S_IDLE, 1'b1, 1'b0, 1'b0, {D*W{1'b0}}, {D{1'b0}}};
        rst_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            start_raw = 1'($urandom);
            lap_raw   = 1'($urandom);
            clear_raw = 1'($urandom);
            val       = W'($urandom);
            tick(1);
            checks++;
            if ({state, tick_stop, cnt_rst, lap_pulse, hist, valid} !== exp_rst) begin
                errors++;
                $display("FAIL reset_values: got %h, expected %h",
                         {state, tick_stop, cnt_rst, lap_pulse, hist, valid}, exp_rst);
            end
        end
        start_raw = 1'b0; lap_raw = 1'b0; clear_raw = 1'b0; val = '0;
        tick(1);
        rst_n = 1'b1;
        tick(10);
        check_outputs("after_reset_release");
    endtask

    task automatic test_debounce();
        start_raw = 1'b1; tick(3);
        start_raw = 1'b0; tick(12);
        check_outputs("short_pulse_ignored");
        start_raw = 1'b1; tick(2);
        start_raw = 1'b0; tick(1);
        start_raw = 1'b1; tick(2);
        start_raw = 1'b0; tick(12);
        check_outputs("bounce_restarts");
        press_start();
    endtask

    task automatic test_lap_history();
        int base;
        base = n_lap;
        toggle_lap(6'd5, 1'b1);
        toggle_lap(6'd9, 1'b1);
        toggle_lap(6'd17, 1'b1);
        toggle_lap(6'd33, 1'b1);
        checks++;
        if (n_lap - base !== 4) begin
            errors++;
            $display("FAIL lap_count: got %0d pulses, expected 4", n_lap - base);
        end
        checks++;
        if ({hist, valid} !== {6'd9, 6'd17, 6'd33, 3'b111}) begin
            errors++;
            $display("FAIL lap_full_history: got %h, expected %h", {hist, valid}, {6'd9, 6'd17, 6'd33, 3'b111});
        end
        check_outputs("lap_history_model");
    endtask

    task automatic test_pause();
        press_start();
        toggle_lap(6'd40, 1'b1);
        checks++;
        if (hist[W-1:0] !== 6'd40) begin
            errors++;
            $display("FAIL pause_lap_entry0: got %0d, expected 40", hist[W-1:0]);
        end
        press_start();
    endtask

    task automatic test_simultaneous();
        int base_rst, base_lap;
        base_rst = n_cnt_rst;
        base_lap = n_lap;
        start_raw = 1'b1;
        clear_raw = 1'b1;
        lap_raw   = ~lap_raw;
        val       = 6'd7;
        tick(7);
        m_state = S_IDLE;
        model_wipe();
        check_outputs("simul_clear_wins");
        start_raw = 1'b0;
        clear_raw = 1'b0;
        tick(10);
        checks++;
        if (n_cnt_rst - base_rst !== 1) begin
            errors++;
            $display("FAIL cnt_rst_pulse: got %0d cycles, expected 1", n_cnt_rst - base_rst);
        end
        checks++;
        if (n_lap !== base_lap) begin
            errors++;
            $display("FAIL simul_no_lap: got %0d pulses, expected 0", n_lap - base_lap);
        end
    endtask

    task automatic test_lap_idle();
        int base;
        base = n_lap;
        toggle_lap(6'd11, 1'b0);
        check_outputs("lap_idle_ignored");
        checks++;
        if (n_lap !== base) begin
            errors++;
            $display("FAIL lap_idle_pulse: got %0d pulses, expected 0", n_lap - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        if (lap_raw) toggle_lap(6'd0, 1'b0);
        press_start();
        lap_raw = 1'b1;
        val = 6'd21;
        tick(5);
        rst_n = 1'b0;
        #1;
        m_state = S_IDLE;
        model_wipe();
        check_outputs("reset_mid_run");
        tick(2);
        rst_n = 1'b1;
        base = n_lap;
        tick(12);
        check_outputs("lap_after_reset_idle");
        press_start();
        checks++;
        if (n_lap !== base || hist !== '0) begin
            errors++;
            $display("FAIL reset_lost_lap: got %0d pulses hist=%h, expected 0 pulses hist=0", n_lap - base, hist);
        end
        toggle_lap(6'd23, 1'b1);
        checks++;
        if (n_lap - base !== 1) begin
            errors++;
            $display("FAIL lap_after_start: got %0d pulses, expected 1", n_lap - base);
        end
        check_outputs("reset_mid_final");
    endtask

    initial begin
        m_state = S_IDLE;
        model_wipe();
        test_reset();
        test_debounce();
        test_lap_history();
        test_pause();
        test_simultaneous();
        test_lap_idle();
        test_reset_mid();
        tick(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d captures never seen, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/pause/clear and lap-history controller for the one-second tick → counter → seven-segment display chain. Synchronizes and debounces three raw board inputs, sequences the tick generator's stop input and the counter's reset through a three-state FSM, and keeps a shift history of captured counter values. The history feeds the `drv_segment_txt` digits.

## Interface
- `p_width`, 6, bit width of the counter value and of each history entry
- `p_depth`, 3, number of history entries
- `p_db_cycles`, 1_000_000, consecutive stable cycles required to accept a new input level (≥2)

- `i_clk`  in  1  system clock
- `i_rst`  in  1  reset, asynchronous, active-low
- `i_start_stop`  in  1  raw push button, asynchronous; rising edge toggles run/pause
- `i_lap`  in  1  raw toggle switch, asynchronous; either edge requests a lap capture
- `i_clear`  in  1  raw push button, asynchronous; rising edge clears
- `i_val`  in  p_width  current counter value
- `o_tick_stop`  out  1  high = tick generator halted
- `o_cnt_rst`  out  1  one-cycle active-high reset pulse to counter
- `o_hist`  out  p_depth*p_width  packed history; entry 0 (newest) in bits [p_width-1:0]
- `o_valid`  out  p_depth  per-entry valid; bit i ↔ entry i
- `o_state`  out  2  00 IDLE, 01 RUN, 10 PAUSE
- `o_lap`  out  1  one-cycle pulse when a capture takes effect

## Operation
- Each raw input passes through a 2-flop synchronizer and then a debouncer.
  - Debouncer counter: cleared whenever the synced level equals the debounced level; increments otherwise.
  - On reaching `p_db_cycles`-1 with the level still differing, the debounced level updates at the next edge.
  - A one-cycle event fires coincident with the update: start and clear on rising edges only, lap on both edges.
- FSM, with clear having priority over start and lap:
  - IDLE: start → RUN. Lap ignored. Clear → stay IDLE, pulse `o_cnt_rst`, wipe history.
  - RUN: start → PAUSE. Lap → capture. Clear → IDLE, pulse `o_cnt_rst`, wipe history.
  - PAUSE: start → RUN. Lap → capture. Clear → IDLE, pulse `o_cnt_rst`, wipe history.
- `o_tick_stop` = 0 only in RUN.
- Capture:
  - entry0 ← `i_val` sampled on the decode cycle; entry i ← entry i-1.
  - `o_valid` ← {`o_valid`[p_depth-2:0], 1}.
  - When full, the oldest entry is discarded silently.
- Start and lap in the same cycle in RUN or PAUSE: the capture occurs and the state toggles.
- Clear in the same cycle as start and/or lap: only the clear takes effect. No `o_lap`, no capture.
- History wipe: all entries 0, `o_valid` = 0.

## Timing
- Reset values (async, while `i_rst`=0):
  - state IDLE.
  - `o_tick_stop`=1, `o_cnt_rst`=0, `o_lap`=0, `o_hist`=0, `o_valid`=0.
  - Synchronizers, debounced levels and debounce counters all 0.
- A raw input held high through reset release produces its event after a full debounce.
- Latency: let edge k be the first edge that samples the new raw level.
  - Synced level changes after edge k+1.
  - Debounced level and event change after edge k+1+`p_db_cycles`.
  - State, `o_tick_stop`, history, `o_valid`, `o_lap` and `o_cnt_rst` update after edge k+2+`p_db_cycles`.
- `o_lap` and `o_cnt_rst` are registered and high for exactly one cycle.
  - Each pulse coincides with the first cycle the new history or state is visible.
- A raw pulse shorter than `p_db_cycles` synced cycles produces no event. Bounces restart the count.
- Reset asserted mid-debounce or mid-run: immediate return to reset values. Partial counts are lost.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
With `p_db_cycles`=4, `p_width`=6, `p_depth`=3:
- **Reset:** `i_rst`=0 with all raw inputs toggling → `o_state`=00, `o_tick_stop`=1, `o_hist`=0, `o_valid`=000, no pulses.
- **Debounce filter:** `i_start_stop` high 3 cycles, then low → no state change. Held high 10 cycles → `o_state`=01 exactly after edge k+6. Bouncing 1-0-1 restarts the count.
- **Lap history:** in RUN, four lap toggles with `i_val`=5, 9, 17, 33 → four `o_lap` pulses. Final entries {33, 17, 9}, `o_valid`=111. Lap toggle in IDLE → no capture.
- **Pause:** start in RUN → PAUSE, `o_tick_stop`=1. Lap with `i_val`=40 → entry0=40. Start → RUN, `o_tick_stop`=0.
- **Simultaneous events:** clear, start and lap debounced on the same cycle in RUN → IDLE, one `o_cnt_rst` pulse, `o_hist`=0, `o_valid`=000, no `o_lap`.
- **Reset mid-operation:** reset in RUN with the lap debounce counter at 3 → immediate IDLE. After release, lap needs a full 4-cycle debounce plus a start before any capture.
